uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// Oversampling UART receiver feeding the ASCII-hex-to-fixed-point assembler.
// Recovers 8N1 frames, or 8-data + parity + 1-stop frames when the macro
// UART_RX_PARITY_EN is defined (PARITY_ODD then picks odd/even sense).
// Each bit is decided by a 3-sample majority vote around mid-bit.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   rxd        in   asynchronous serial line, idle high
//   asc        out  [7:0] last good byte (held until the next good byte)
//   start      out  one-cycle pulse: asc newly updated
//   dataerror  out  one-cycle pulse: parity mismatch (0 without parity)
//   frameerror out  one-cycle pulse: stop bit sampled low
//   busy       out  high from start-bit detect until the FSM is back in IDLE
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] asc,
    output logic       start,
    output logic       dataerror,
    output logic       frameerror,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

    // Reject parameter sets the sampling scheme cannot support.
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DIV < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Expected parity bit for a data byte in the configured sense.
    function automatic logic parity_bit(input logic [7:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction
`endif

    state_t          state_q, state_d;
    logic            rx_meta_q, rxs_q;
    logic [DW-1:0]   div_q, div_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      smp_q, smp_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      asc_q, asc_d;
    logic            start_q, start_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic            derr_q, derr_d;
    logic            par_err_q, par_err_d;
`endif
    logic            tick_s, vote_s, vote_now_s, bit_end_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= {DW{1'b0}};
            scnt_q    <= {SW{1'b0}};
            bit_q     <= 3'd0;
            smp_q     <= 2'b00;
            hold_q    <= 8'h00;
            asc_q     <= 8'h00;
            start_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            derr_q    <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            scnt_q    <= scnt_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            hold_q    <= hold_d;
            asc_q     <= asc_d;
            start_q   <= start_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            derr_q    <= derr_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next-state, bit timing and output pulse logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        scnt_d  = scnt_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        hold_d  = hold_q;
        asc_d   = asc_q;
        start_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        derr_d    = 1'b0;
        par_err_d = par_err_q;
`endif
        tick_s     = (div_q == DIV_LAST);
        // The third vote sample is the live synchronised line at the S_HI tick.
        vote_s     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
        vote_now_s = tick_s && (scnt_q == S_HI);
        bit_end_s  = tick_s && (scnt_q == S_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (vote_now_s && vote_s) begin
                    state_d = ST_IDLE;              // false start, silent
                end else if (bit_end_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (vote_now_s) begin
                    hold_d = {vote_s, hold_q[7:1]}; // LSB arrives first
                end else begin
                    hold_d = hold_q;
                end
                if (bit_end_s && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else if (bit_end_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_now_s) begin
                    par_err_d = (vote_s != parity_bit(hold_q));
                end else begin
                    par_err_d = par_err_q;
                end
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // Decide at the mid-bit vote so back-to-back frames are not missed.
                if (vote_now_s) begin
                    if (!vote_s) begin
                        ferr_d  = 1'b1;             // framing error outranks parity
                        state_d = ST_BREAK;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_err_q) begin
                        derr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                    else begin
                        asc_d   = hold_q;
                        start_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timers run only inside a frame; they restart from 0 on every start detect.
        if (state_q == ST_IDLE || state_q == ST_BREAK ||
            state_d == ST_IDLE || state_d == ST_BREAK) begin
            div_d  = {DW{1'b0}};
            scnt_d = {SW{1'b0}};
        end else if (tick_s) begin
            div_d = {DW{1'b0}};
            if (scnt_q == S_LAST) begin
                scnt_d = {SW{1'b0}};
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
            if (scnt_q == S_LO) begin
                smp_d = {smp_q[1], rxs_q};
            end else if (scnt_q == S_MID) begin
                smp_d = {rxs_q, smp_q[0]};
            end else begin
                smp_d = smp_q;
            end
        end else begin
            div_d  = div_q + 1'b1;
            scnt_d = scnt_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign asc        = asc_q;
    assign start      = start_q;
    assign frameerror = ferr_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign dataerror  = derr_q;
`else
    assign dataerror  = 1'b0;
`endif

endmodule
